// File: rtl/unified_mem_arbiter_if.sv
// Pipeline-side request/response and SRAM-side pins of the unified memory arbiter.
// The slave modport is the arbiter's view; master is the environment (core + SRAM).
interface unified_mem_arbiter_if #(
  parameter int AW = 10
);
  logic          IREQ;
  logic [29:0]   IADDR;
  logic [31:0]   INSTR;
  logic          IVALID;
  logic          ISTALL;
  logic          DREQ;
  logic          DRW;
  logic [29:0]   DADDR;
  logic [31:0]   DWDATA;
  logic [31:0]   DRDATA;
  logic          DVALID;
  logic          DSTALL;
  logic          MCSN;
  logic          MWEN;
  logic [AW-1:0] MA;
  logic [31:0]   MDI;
  logic [31:0]   MDOUT;

  modport slave (
    input  IREQ, IADDR, DREQ, DRW, DADDR, DWDATA, MDOUT,
    output INSTR, IVALID, ISTALL, DRDATA, DVALID, DSTALL, MCSN, MWEN, MA, MDI
  );

  modport master (
    output IREQ, IADDR, DREQ, DRW, DADDR, DWDATA, MDOUT,
    input  INSTR, IVALID, ISTALL, DRDATA, DVALID, DSTALL, MCSN, MWEN, MA, MDI
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port SRAM between instruction fetch and data access.
// Data wins by default; a starvation counter forces fetch after STARVE_MAX denials.
module unified_mem_arbiter #(
  parameter int AW         = 10,
  parameter int STARVE_MAX = 4
) (
  input  logic                CLK,
  input  logic                RSTN,
  unified_mem_arbiter_if.slave bus
);
  localparam int SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {RSP_NONE, RSP_INST, RSP_DATA} rsp_e;

  rsp_e          rsp_sel;
  logic [SW-1:0] starve_cnt;
  logic [31:0]   instr_q, drdata_q;
  logic          starved, fetch_grant, data_grant;
  logic          unused_addr_hi;

  assign unused_addr_hi = ^{bus.IADDR[29:AW], bus.DADDR[29:AW]};

  assign starved     = (STARVE_MAX != 0) && (starve_cnt == SW'(STARVE_MAX));
  assign fetch_grant = bus.IREQ && (!bus.DREQ || starved);
  assign data_grant  = bus.DREQ && !fetch_grant;

  assign bus.ISTALL = bus.IREQ && !fetch_grant;
  assign bus.DSTALL = bus.DREQ && !data_grant;

  // Reset gates the strobes so no SRAM access happens while RSTN is low.
  assign bus.MCSN = !(RSTN && (fetch_grant || data_grant));
  assign bus.MWEN = !(RSTN && data_grant && bus.DRW);

  always_comb begin
    bus.MA  = '0;
    bus.MDI = '0;
    if (fetch_grant) begin
      bus.MA = bus.IADDR[AW-1:0];
    end else if (data_grant) begin
      bus.MA  = bus.DADDR[AW-1:0];
      bus.MDI = bus.DWDATA;
    end
  end

  // The SRAM output register already holds the response in the valid cycle,
  // so it is forwarded there and captured to hold it afterwards.
  assign bus.IVALID = (rsp_sel == RSP_INST);
  assign bus.DVALID = (rsp_sel == RSP_DATA);
  assign bus.INSTR  = bus.IVALID ? bus.MDOUT : instr_q;
  assign bus.DRDATA = bus.DVALID ? bus.MDOUT : drdata_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rsp_sel    <= RSP_NONE;
      starve_cnt <= '0;
      instr_q    <= '0;
      drdata_q   <= '0;
    end else begin
      if (rsp_sel == RSP_INST) instr_q  <= bus.MDOUT;
      if (rsp_sel == RSP_DATA) drdata_q <= bus.MDOUT;

      if (fetch_grant)                  rsp_sel <= RSP_INST;
      else if (data_grant && !bus.DRW)  rsp_sel <= RSP_DATA;
      else                              rsp_sel <= RSP_NONE;

      if (!bus.IREQ || fetch_grant)     starve_cnt <= '0;
      else if (!starved && (starve_cnt != SW'(STARVE_MAX)))
                                        starve_cnt <= starve_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed vector table, corner sequences and
// random traffic checked against a transaction-level model with a shadow memory.
module tb_unified_mem_arbiter;
  localparam int AW   = 10;
  localparam int SMAX = 4;
  localparam int MW   = 1 << AW;

  logic CLK  = 1'b0;
  logic RSTN = 1'b0;
  always #5 CLK = ~CLK;

  unified_mem_arbiter_if #(.AW(AW)) bus();
  unified_mem_arbiter #(.AW(AW), .STARVE_MAX(SMAX)) dut (.CLK(CLK), .RSTN(RSTN), .bus(bus));

  // SRAM device driven purely by the DUT pins
  logic [31:0] sram [MW] = '{default: 32'h0};
  always @(posedge CLK) begin
    if (!bus.MCSN) begin
      if (!bus.MWEN) sram[bus.MA] <= bus.MDI;
      else           bus.MDOUT    <= sram[bus.MA];
    end
  end

  // reference model state
  logic [31:0] shadow [MW] = '{default: 32'h0};
  int          wcnt = 0;
  int          pend = 0;            // 0 none, 1 fetch response due, 2 load response due
  logic [31:0] pend_data = '0;
  logic [31:0] exp_instr = '0;
  logic [31:0] exp_drdata = '0;
  int          n_chk = 0;
  int          n_fail = 0;

  typedef struct {
    logic        ireq;
    logic [29:0] iaddr;
    logic        dreq;
    logic        drw;
    logic [29:0] daddr;
    logic [31:0] dwdata;
    logic        eis, eds, emcsn, emwen;
    logic [9:0]  ema;
    logic        eiv, edv;
    logic [31:0] erd;
  } vec_t;

  vec_t tv [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ireq, input logic [29:0] iaddr, input logic dreq,
                       input logic drw, input logic [29:0] daddr, input logic [31:0] dwdata);
    bus.IREQ   = ireq;
    bus.IADDR  = iaddr;
    bus.DREQ   = dreq;
    bus.DRW    = drw;
    bus.DADDR  = daddr;
    bus.DWDATA = dwdata;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    wcnt = 0; pend = 0; exp_instr = '0; exp_drdata = '0;
  endtask

  // Checks the current cycle at the negedge, then advances the model.
  task automatic model_check();
    logic fg, dg;
    logic [AW-1:0] ia, da;
    @(negedge CLK);
    ia = bus.IADDR[AW-1:0];
    da = bus.DADDR[AW-1:0];
    fg = bus.IREQ && (!bus.DREQ || (SMAX != 0 && wcnt == SMAX));
    dg = bus.DREQ && !fg;
    if (pend == 1) exp_instr  = pend_data;
    if (pend == 2) exp_drdata = pend_data;
    chk("ivalid", bus.IVALID, pend == 1);
    chk("dvalid", bus.DVALID, pend == 2);
    chk("instr",  bus.INSTR,  exp_instr);
    chk("drdata", bus.DRDATA, exp_drdata);
    chk("istall", bus.ISTALL, bus.IREQ && !fg);
    chk("dstall", bus.DSTALL, bus.DREQ && !dg);
    chk("mcsn",   bus.MCSN,   !(fg || dg));
    chk("mwen",   bus.MWEN,   !(dg && bus.DRW));
    if (fg || dg) chk("ma", bus.MA, fg ? ia : da);
    if (dg && bus.DRW) chk("mdi", bus.MDI, bus.DWDATA);
    if (fg)                  begin pend = 1; pend_data = shadow[ia]; end
    else if (dg && !bus.DRW) begin pend = 2; pend_data = shadow[da]; end
    else                     pend = 0;
    if (dg && bus.DRW) shadow[da] = bus.DWDATA;
    if (!bus.IREQ || fg) wcnt = 0;
    else if (wcnt < SMAX) wcnt = wcnt + 1;
  endtask

  initial begin
    logic [29:0] ra, rb;

    //            ireq iaddr          dreq drw daddr  dwdata        is ds cs we ma     iv dv erd
    tv[0]  = '{1'b0, 30'd0,         1'b1, 1'b1, 30'd5,  32'h1234_5678, 0, 0, 0, 0, 10'd5,  0, 0, 32'h0};
    tv[1]  = '{1'b0, 30'd0,         1'b1, 1'b1, 30'd3,  32'h3333_0003, 0, 0, 0, 0, 10'd3,  0, 0, 32'h0};
    tv[2]  = '{1'b0, 30'd0,         1'b1, 1'b1, 30'd7,  32'h7777_0007, 0, 0, 0, 0, 10'd7,  0, 0, 32'h0};
    tv[3]  = '{1'b1, 30'd5,         1'b0, 1'b0, 30'd0,  32'h0,         0, 0, 0, 1, 10'd5,  0, 0, 32'h0};
    tv[4]  = '{1'b0, 30'd0,         1'b0, 1'b0, 30'd0,  32'h0,         0, 0, 1, 1, 10'd0,  1, 0, 32'h1234_5678};
    tv[5]  = '{1'b0, 30'd0,         1'b1, 1'b1, 30'h40, 32'hDEAD_BEEF, 0, 0, 0, 0, 10'h40, 0, 0, 32'h0};
    tv[6]  = '{1'b0, 30'd0,         1'b1, 1'b0, 30'h40, 32'h0,         0, 0, 0, 1, 10'h40, 0, 0, 32'h0};
    tv[7]  = '{1'b0, 30'd0,         1'b0, 1'b0, 30'd0,  32'h0,         0, 0, 1, 1, 10'd0,  0, 1, 32'hDEAD_BEEF};
    tv[8]  = '{1'b1, 30'd5,         1'b1, 1'b0, 30'd3,  32'h0,         1, 0, 0, 1, 10'd3,  0, 0, 32'h0};
    tv[9]  = '{1'b1, 30'd5,         1'b0, 1'b0, 30'd0,  32'h0,         0, 0, 0, 1, 10'd5,  0, 1, 32'h3333_0003};
    tv[10] = '{1'b0, 30'd0,         1'b1, 1'b0, 30'd3,  32'h0,         0, 0, 0, 1, 10'd3,  1, 0, 32'h1234_5678};
    tv[11] = '{1'b1, 30'd7,         1'b0, 1'b0, 30'd0,  32'h0,         0, 0, 0, 1, 10'd7,  0, 1, 32'h3333_0003};
    tv[12] = '{1'b1, 30'h3FFF_FC05, 1'b0, 1'b0, 30'd0,  32'h0,         0, 0, 0, 1, 10'd5,  1, 0, 32'h7777_0007};
    tv[13] = '{1'b0, 30'd0,         1'b0, 1'b0, 30'd0,  32'h0,         0, 0, 1, 1, 10'd0,  1, 0, 32'h1234_5678};

    // reset state, with requests present: strobes must stay inactive
    drive(1'b1, 30'd9, 1'b1, 1'b1, 30'd9, 32'hFFFF_FFFF);
    #1;
    chk("rst.instr",  bus.INSTR,  32'h0);
    chk("rst.drdata", bus.DRDATA, 32'h0);
    chk("rst.ivalid", bus.IVALID, 1'b0);
    chk("rst.dvalid", bus.DVALID, 1'b0);
    chk("rst.mcsn",   bus.MCSN,   1'b1);
    chk("rst.mwen",   bus.MWEN,   1'b1);
    chk("rst.istall", bus.ISTALL, 1'b1);
    chk("rst.dstall", bus.DSTALL, 1'b0);
    drive(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'h0);
    repeat (2) @(posedge CLK);
    @(negedge CLK) RSTN = 1'b1;
    tick();

    // directed vector table
    for (int i = 0; i < 14; i++) begin
      drive(tv[i].ireq, tv[i].iaddr, tv[i].dreq, tv[i].drw, tv[i].daddr, tv[i].dwdata);
      model_check();
      chk($sformatf("tv%0d.istall", i), bus.ISTALL, tv[i].eis);
      chk($sformatf("tv%0d.dstall", i), bus.DSTALL, tv[i].eds);
      chk($sformatf("tv%0d.mcsn", i),   bus.MCSN,   tv[i].emcsn);
      chk($sformatf("tv%0d.mwen", i),   bus.MWEN,   tv[i].emwen);
      if (!tv[i].emcsn) chk($sformatf("tv%0d.ma", i), bus.MA, tv[i].ema);
      chk($sformatf("tv%0d.ivalid", i), bus.IVALID, tv[i].eiv);
      chk($sformatf("tv%0d.dvalid", i), bus.DVALID, tv[i].edv);
      if (tv[i].eiv) chk($sformatf("tv%0d.instr", i),  bus.INSTR,  tv[i].erd);
      if (tv[i].edv) chk($sformatf("tv%0d.drdata", i), bus.DRDATA, tv[i].erd);
      tick();
    end

    // starvation: data wins four times, fetch forced on the fifth, then data again
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 30'd7, 1'b1, 1'b0, 30'd3, 32'h0);
      model_check();
      chk($sformatf("starve%0d.istall", k), bus.ISTALL, k != 4);
      chk($sformatf("starve%0d.dstall", k), bus.DSTALL, k == 4);
      tick();
    end
    drive(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'h0);
    model_check();
    tick();

    // reset while a load response is in flight
    drive(1'b0, 30'd0, 1'b1, 1'b0, 30'h40, 32'h0);
    model_check();
    tick();
    RSTN = 1'b0;
    #1;
    chk("midrst.dvalid", bus.DVALID, 1'b0);
    chk("midrst.ivalid", bus.IVALID, 1'b0);
    chk("midrst.drdata", bus.DRDATA, 32'h0);
    chk("midrst.mcsn",   bus.MCSN,   1'b1);
    model_reset();
    @(posedge CLK);
    drive(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'h0);
    @(negedge CLK) RSTN = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      model_check();
      tick();
    end

    // random traffic, biased towards contention
    for (int n = 0; n < 400; n++) begin
      ra = 30'($urandom);
      rb = 30'($urandom);
      ra[9:0] = 10'($urandom_range(0, 15));
      rb[9:0] = 10'($urandom_range(0, 15));
      drive($urandom_range(0, 3) != 0, ra, $urandom_range(0, 2) != 0,
            $urandom_range(0, 1) == 1, rb, $urandom);
      model_check();
      tick();
    end
    drive(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'h0);
    model_check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port synchronous SRAM (active-low CSN/WEN, 1-cycle read latency) between the core's instruction-fetch port and data-access port.
- Sits between the pipeline top (IREQ/IADDR/INSTR and DREQ/DRW/DADDR/DWDATA/DRDATA) and a single SRAM instance.
- Data requests have fixed priority over fetch; a starvation counter forces a fetch grant after a bounded wait.
- Per-port stall outputs let the pipeline freeze the losing stage.

Parameters:
AW, 10, SRAM word-address width; requester word addresses are truncated to AW LSBs
STARVE_MAX, 4, consecutive fetch denials before fetch is forced to win; 0 = pure data priority (no forcing)

Ports:
CLK  input  1  clock, rising edge
RSTN  input  1  asynchronous active-low reset
IREQ  input  1  instruction read request
IADDR  input  30  instruction word address
INSTR  output  32  instruction data, registered, held between responses
IVALID  output  1  INSTR updated this cycle (response to previous-cycle grant)
ISTALL  output  1  IREQ present but not granted this cycle (combinational)
DREQ  input  1  data request
DRW  input  1  1 = write, 0 = read
DADDR  input  30  data word address
DWDATA  input  32  write data
DRDATA  output  32  load data, registered, held between responses
DVALID  output  1  DRDATA updated this cycle (read responses only)
DSTALL  output  1  DREQ present but not granted this cycle (combinational)
MCSN  output  1  SRAM chip select, active low
MWEN  output  1  SRAM write enable, active low
MA  output  AW  SRAM word address
MDI  output  32  SRAM write data
MDOUT  input  32  SRAM read data, valid one cycle after read access

Behaviour:
- Grant logic is combinational from the current requests and the starve counter. Default grant is data.
- Fetch is granted when:
  - IREQ && !DREQ, or
  - IREQ && DREQ && STARVE_MAX != 0 && starve_cnt == STARVE_MAX.
- Stall outputs:
  - ISTALL = IREQ && !fetch_grant.
  - DSTALL = DREQ && !data_grant.
  - Both are 0 when the port is not requesting.
- SRAM drive:
  - MCSN = !(fetch_grant || data_grant).
  - MWEN = !(data_grant && DRW); a fetch is always a read.
  - MA = granted port's address[AW-1:0]; MDI = DWDATA.
  - When idle, MA and MDI are don't-care but must not be X-propagating; drive 0.
- Starve counter:
  - Width is enough to hold STARVE_MAX.
  - Increments when IREQ && !fetch_grant.
  - Clears when a fetch is granted or IREQ = 0.
  - Saturates at STARVE_MAX.
- Response tracking register rsp_sel has states NONE, INST, DATA. Next state:
  - INST if fetch granted;
  - DATA if a data read is granted;
  - NONE otherwise, including a data write.
- Response routing in the cycle after the grant:
  - rsp_sel = INST: INSTR <= MDOUT, IVALID = 1.
  - rsp_sel = DATA: DRDATA <= MDOUT, DVALID = 1.
  - IVALID and DVALID are registered-state-derived and never both 1.
- Write latency is 0 extra cycles: a write completes in its grant cycle (DREQ && DRW && !DSTALL). DVALID is not asserted for writes.
- Read latency is 1 cycle from grant to xVALID.
- Back-to-back: a grant is legal every cycle. A response and a new grant may coincide, e.g. data read response in cycle n+1 while fetch is granted in n+1.
- INSTR and DRDATA hold their last value when no response arrives. The requester must sample only on xVALID.
- Reset values (asynchronous, immediate on RSTN low):
  - INSTR = 0, DRDATA = 0, IVALID = 0, DVALID = 0.
  - rsp_sel = NONE, starve_cnt = 0.
  - The combinational outputs follow requests. MCSN = 1 and MWEN = 1 while RSTN = 0, overriding grants.
- Reset mid-operation: an in-flight read is discarded. No xVALID is asserted after RSTN deasserts until a new grant occurs.
- Address truncation: IADDR/DADDR bits above AW-1 are ignored, with no error flag.
- Requests must be held stable by the requester while xSTALL = 1. The arbiter keeps no request copy.

Test Plan:
- Fetch only: IREQ=1, IADDR=5 with SRAM[5]=0x1234_5678 -> MCSN=0, MWEN=1, MA=5, ISTALL=0; next cycle IVALID=1, INSTR=0x1234_5678.
- Data write then read: DREQ=1, DRW=1, DADDR=0x40, DWDATA=0xDEAD_BEEF -> MWEN=0, DVALID stays 0. Then a read at 0x40 -> DVALID=1 next cycle, DRDATA=0xDEAD_BEEF.
- Conflict with priority: IREQ=DREQ=1 for 1 cycle -> DSTALL=0, ISTALL=1, starve_cnt=1. With DREQ dropped the next cycle -> fetch granted, counter cleared.
- Starvation with STARVE_MAX=4, IREQ=DREQ=1 held -> data granted in cycles 0-3, fetch forced in cycle 4 (DSTALL=1, ISTALL=0), data again in cycle 5.
- Pipelined alternation: data read at 3 in cycle n, fetch at 7 in cycle n+1 -> DVALID in n+1 with SRAM[3], IVALID in n+2 with SRAM[7], never both valid.
- Reset mid-read: grant a data read, assert RSTN=0 the next cycle before the clock edge -> DVALID=0, DRDATA=0, MCSN=1. After release with no requests, no xVALID is ever asserted.
